ib_fetch_credit_ctrl: RTL and testbench

- Credit-based flow controller between the fetch unit and the instruction buffer.
- Tracks buffer occupancy and outstanding fetch requests; grants a new fetch request only when the buffer is guaranteed to have room for its response.
- Sequences branch-miss flush recovery by draining stale in-flight fetch responses before fetching resumes.

---
 rtl/ib_fetch_credit_ctrl.sv | 80 ++++++++
 tb/tb_ib_fetch_credit_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ib_fetch_credit_ctrl.sv
// ib_fetch_credit_ctrl: credit-based fetch request gating and flush drain sequencing for the instruction buffer.
// Define IB_FETCH_CREDIT_PERF_EN to build the stall/empty performance counters.
module ib_fetch_credit_ctrl #(
  parameter int BUFFER_SIZE  = 8,
  parameter int IF_WIDTH     = 2,
  parameter int ID_WIDTH     = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              fetch_valid_i,
  output logic                              fetch_grant_o,
  input  logic                              fetch_resp_valid_i,
  input  logic [$clog2(IF_WIDTH):0]         fetch_resp_num_i,
  output logic                              resp_write_en_o,
  input  logic [$clog2(ID_WIDTH):0]         backend_accept_num_i,
  input  logic                              flush_i,
  output logic [$clog2(BUFFER_SIZE):0]      occupancy_o,
  output logic [$clog2(MAX_INFLIGHT):0]     inflight_o,
  output logic                              busy_o,
  output logic [31:0]                       perf_stall_cnt_o,
  output logic [31:0]                       perf_empty_cnt_o
);
  localparam int OW = $clog2(BUFFER_SIZE) + 1;
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  localparam int CW = OW + IW + 2;
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_next;
  logic [OW-1:0] occ, occ_next;
  logic [IW-1:0] inflight, inflight_next, stale, stale_next;
  logic [OW:0] occ_sum;
  logic [IW:0] stale_sum;
  logic signed [CW-1:0] credits;
  logic draining;
  always_comb begin
    credits = $signed(CW'(BUFFER_SIZE)) - $signed(CW'(occ)) - $signed(CW'(IF_WIDTH)) * $signed(CW'(inflight));
    fetch_grant_o = rst_n && fetch_valid_i && state == RUN && !flush_i &&
                    inflight < IW'(MAX_INFLIGHT) && credits >= $signed(CW'(IF_WIDTH));
    resp_write_en_o = rst_n && fetch_resp_valid_i && state == RUN && !flush_i && inflight != '0;
    occ_sum = (OW+1)'(occ) + (resp_write_en_o ? (OW+1)'(fetch_resp_num_i) : (OW+1)'(0));
    occ_next = occ_sum > (OW+1)'(backend_accept_num_i) ? OW'(occ_sum - (OW+1)'(backend_accept_num_i)) : '0;
    // A flush turns every live request into a stale one still owed a response.
    stale_sum = (IW+1)'(flush_i ? inflight : IW'(0)) + (IW+1)'(stale);
    stale_next = stale_sum > (IW+1)'(fetch_resp_valid_i) ? IW'(stale_sum - (IW+1)'(fetch_resp_valid_i)) : '0;
    draining = flush_i || state == DRAIN;
    inflight_next = flush_i ? '0 : state == DRAIN ? inflight : inflight + IW'(fetch_grant_o) - IW'(resp_write_en_o);
    state_next = draining && stale_next != '0 ? DRAIN : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      occ      <= '0;
      inflight <= '0;
      stale    <= '0;
      state    <= RUN;
    end else begin
      occ      <= flush_i ? '0 : occ_next;
      inflight <= inflight_next;
      stale    <= draining ? stale_next : stale;
      state    <= state_next;
    end
  assign occupancy_o = occ;
  assign inflight_o  = inflight;
  assign busy_o      = state == DRAIN;
`ifdef IB_FETCH_CREDIT_PERF_EN
  logic [31:0] stall_cnt, empty_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      empty_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(fetch_valid_i && !fetch_grant_o);
      empty_cnt <= empty_cnt + 32'(occ == '0);
    end
  assign perf_stall_cnt_o = stall_cnt;
  assign perf_empty_cnt_o = empty_cnt;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_empty_cnt_o = '0;
`endif
endmodule

// File: tb/tb_ib_fetch_credit_ctrl.sv
// tb_ib_fetch_credit_ctrl: directed stimulus against a cycle-level occupancy/credit model plus literal expectations.
module tb_ib_fetch_credit_ctrl;
  logic clk = 0, rst_n = 0, fv = 0, rv = 0, fl = 0;
  logic [1:0] rn = 0, acc = 0;
  logic grant, wen, busy;
  logic [3:0] occ;
  logic [2:0] inf;
  logic [31:0] pst, pem;
  int errs = 0, checks = 0;
  int m_occ = 0, m_inf = 0, m_stale = 0, m_st = 0, m_em = 0;
  bit m_drain = 0;

  ib_fetch_credit_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid_i(fv), .fetch_grant_o(grant),
    .fetch_resp_valid_i(rv), .fetch_resp_num_i(rn), .resp_write_en_o(wen),
    .backend_accept_num_i(acc), .flush_i(fl), .occupancy_o(occ), .inflight_o(inf),
    .busy_o(busy), .perf_stall_cnt_o(pst), .perf_empty_cnt_o(pem)
  );

  always #5 clk = ~clk;

  function automatic int max0(int x);
    return x < 0 ? 0 : x;
  endfunction

  function automatic bit e_grant();
    return rst_n && fv && !m_drain && !fl && m_inf < 4 && (8 - m_occ - 2 * m_inf) >= 2;
  endfunction

  function automatic bit e_wen();
    return rst_n && rv && !m_drain && !fl && m_inf > 0;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    bit g, w;
    if (!rst_n) begin
      m_occ = 0; m_inf = 0; m_stale = 0; m_drain = 0; m_st = 0; m_em = 0;
    end else begin
      g = e_grant();
      w = e_wen();
      m_st += int'(fv && !g);
      m_em += int'(m_occ == 0);
      if (fl) begin
        m_stale = max0(m_inf + m_stale - int'(rv));
        m_occ = 0;
        m_inf = 0;
        m_drain = m_stale > 0;
      end else if (m_drain) begin
        m_stale = max0(m_stale - int'(rv));
        m_occ = max0(m_occ - int'(acc));
        m_drain = m_stale > 0;
      end else begin
        m_occ = max0(m_occ + (w ? int'(rn) : 0) - int'(acc));
        m_inf += int'(g) - int'(w);
      end
    end
  end

  always @(negedge clk) begin
    chk("grant", 32'(grant), 32'(e_grant()));
    chk("wen", 32'(wen), 32'(e_wen()));
    chk("occ", 32'(occ), 32'(m_occ));
    chk("inflight", 32'(inf), 32'(m_inf));
    chk("busy", 32'(busy), 32'(m_drain));
`ifdef IB_FETCH_CREDIT_PERF_EN
    chk("perf_stall", pst, 32'(m_st));
    chk("perf_empty", pem, 32'(m_em));
`else
    chk("perf_stall", pst, 32'(0));
    chk("perf_empty", pem, 32'(0));
`endif
  end

  task automatic step(bit v, bit r, int n, int a, bit f);
    @(posedge clk);
    #1;
    fv = v; rv = r; rn = 2'(n); acc = 2'(a); fl = f;
    @(negedge clk);
  endtask

  initial begin
    fv = 1;
    #12;
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_occ", 32'(occ), 32'(0));
    chk("rst_inf", 32'(inf), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    fv = 0;
    #10 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0);
      chk("burst_grant", 32'(grant), 32'(1));
    end
    step(1, 0, 0, 0, 0);
    chk("burst_stop", 32'(grant), 32'(0));
    chk("burst_inf", 32'(inf), 32'(4));
    chk("burst_occ", 32'(occ), 32'(0));
    step(1, 0, 0, 0, 0);
`ifdef IB_FETCH_CREDIT_PERF_EN
    chk("stall_first", pst, 32'(1));
`endif
    step(0, 1, 2, 0, 0);
    chk("resp_wen", 32'(wen), 32'(1));
    step(0, 1, 2, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("cred0_occ", 32'(occ), 32'(4));
    chk("cred0_inf", 32'(inf), 32'(2));
    chk("cred0_grant", 32'(grant), 32'(0));
    step(1, 0, 0, 2, 0);
    step(1, 0, 0, 0, 0);
    chk("pop_occ", 32'(occ), 32'(2));
    chk("pop_grant", 32'(grant), 32'(1));
    step(0, 1, 2, 0, 0);
    step(0, 1, 2, 0, 0);
    step(0, 1, 2, 2, 0);
    chk("same_occ_before", 32'(occ), 32'(6));
    chk("same_inf_before", 32'(inf), 32'(1));
    step(0, 0, 0, 0, 0);
    chk("same_occ", 32'(occ), 32'(6));
    chk("same_inf", 32'(inf), 32'(0));
    step(0, 1, 2, 0, 0);
    chk("resp_no_inf", 32'(wen), 32'(0));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 2, 0);
    step(0, 0, 0, 0, 0);
    chk("clamp_occ", 32'(occ), 32'(0));
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 2, 0, 1);
    chk("flush_grant", 32'(grant), 32'(0));
    chk("flush_wen", 32'(wen), 32'(0));
    step(1, 0, 0, 0, 0);
    chk("drain_busy", 32'(busy), 32'(1));
    chk("drain_occ", 32'(occ), 32'(0));
    chk("drain_inf", 32'(inf), 32'(0));
    chk("drain_grant", 32'(grant), 32'(0));
    step(0, 1, 2, 0, 0);
    chk("stale1_wen", 32'(wen), 32'(0));
    step(0, 1, 2, 0, 0);
    chk("stale2_wen", 32'(wen), 32'(0));
    step(1, 0, 0, 0, 0);
    chk("resume_busy", 32'(busy), 32'(0));
    chk("resume_grant", 32'(grant), 32'(1));
    step(1, 1, 2, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("drain2_busy", 32'(busy), 32'(1));
    #2 rst_n = 0;
    #1;
    chk("async_busy", 32'(busy), 32'(0));
    chk("async_occ", 32'(occ), 32'(0));
    chk("async_inf", 32'(inf), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1;
    fv = 1;
    @(negedge clk);
    chk("post_rst_grant", 32'(grant), 32'(1));
    step(0, 1, 2, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("flush0_busy", 32'(busy), 32'(0));
    step(0, 0, 0, 0, 0);
    chk("flush0_busy_next", 32'(busy), 32'(0));
    chk("flush0_occ", 32'(occ), 32'(0));
    step(0, 0, 0, 0, 0);
    chk("flush0_busy_late", 32'(busy), 32'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
